// File: rtl/z80_io_port_fsm.sv
// -----------------------------------------------------------------------------
// z80_io_port_fsm
//
// Z8S180 bus-side IO port decoder, clocked by PHI. It decodes a block of
// 2**PORT_BITS IO ports starting at BASE_ADDR and emits one-cycle write and
// read ticks, one per bus transaction. Every decoded write (port index + data)
// is buffered in a small first-word-fall-through queue that the consumer
// (typically a CDC block) drains at its own pace.
//
// Build option:
//   IORQ_DOUBLE_SYNC_EN  - when defined, the bus inputs go through two flop
//                          stages instead of one; every latency grows by 1 phi.
//
// Ports:
//   phi          in   Z8S180 PHI clock, rising edge
//   reset        in   synchronous, active-high
//   iorq/wr/rd   in   bus strobes, active high
//   ain          in   bus address  [ADDR_WIDTH]
//   din          in   bus write data [DATA_WIDTH]
//   wr_tick      out  one-phi pulse: decoded write captured
//   rd_tick      out  one-phi pulse: decoded read started
//   rd_port      out  port index of the last rd_tick (held)
//   wq_valid     out  queue not empty, head presented on wq_port/wq_data
//   wq_port      out  head entry port index
//   wq_data      out  head entry data
//   wq_pop       in   consume head (ignored while empty)
//   wq_full      out  queue holds DEPTH entries
//   wq_overflow  out  sticky: a write was dropped while full
// -----------------------------------------------------------------------------
module z80_io_port_fsm #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'h80,
   parameter int                    PORT_BITS  = 2,
   parameter int                    DEPTH      = 4
) (
   input  logic                  phi,
   input  logic                  reset,
   input  logic                  iorq,
   input  logic                  wr,
   input  logic                  rd,
   input  logic [ADDR_WIDTH-1:0] ain,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  wr_tick,
   output logic                  rd_tick,
   output logic [PORT_BITS-1:0]  rd_port,
   output logic                  wq_valid,
   output logic [PORT_BITS-1:0]  wq_port,
   output logic [DATA_WIDTH-1:0] wq_data,
   input  logic                  wq_pop,
   output logic                  wq_full,
   output logic                  wq_overflow
);

`ifdef IORQ_DOUBLE_SYNC_EN
   localparam int SYNC_STAGES = 2;
`else
   localparam int SYNC_STAGES = 1;
`endif

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = 3 + ADDR_WIDTH + DATA_WIDTH;
   localparam int EW = PORT_BITS + DATA_WIDTH;

   typedef enum logic {IDLE, WAIT_END} state_t;

   // ---------------------------------------------------------------- sampling
   // All bus signals travel together through the same stages so the strobes
   // and the address/data they qualify stay aligned.
   logic [SW-1:0]          samp_q [SYNC_STAGES];
   logic [SW-1:0]          samp_d [SYNC_STAGES];
   // Marks sample stages that hold a real post-reset bus sample. Until the
   // last stage is valid, its zero reset value must not be mistaken for an
   // idle bus, otherwise a transaction spanning reset release would tick.
   logic [SYNC_STAGES-1:0] vld_pipe_q, vld_pipe_d;

   logic                  s_iorq, s_wr, s_rd, s_valid;
   logic [ADDR_WIDTH-1:0] s_ain;
   logic [DATA_WIDTH-1:0] s_din;
   logic [PORT_BITS-1:0]  s_port;
   logic                  addr_hit;

   always_comb begin
      samp_d[0] = {iorq, wr, rd, ain, din};
      for (int i = 1; i < SYNC_STAGES; i++) samp_d[i] = samp_q[i-1];
      vld_pipe_d = {vld_pipe_q[SYNC_STAGES-1:0], 1'b1} >> 0;
   end

   always_ff @(posedge phi) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) samp_q[i] <= '0;
         vld_pipe_q <= '0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) samp_q[i] <= samp_d[i];
         vld_pipe_q <= vld_pipe_d;
      end
   end

   assign {s_iorq, s_wr, s_rd, s_ain, s_din} = samp_q[SYNC_STAGES-1];
   assign s_valid  = vld_pipe_q[SYNC_STAGES-1];
   assign s_port   = s_ain[PORT_BITS-1:0];
   assign addr_hit = (s_ain[ADDR_WIDTH-1:PORT_BITS] == BASE_ADDR[ADDR_WIDTH-1:PORT_BITS]);

   // --------------------------------------------------------------------- FSM
   state_t               state_q, state_d;
   logic                 wr_tick_q, wr_tick_d;
   logic                 rd_tick_q, rd_tick_d;
   logic [PORT_BITS-1:0] rd_port_q, rd_port_d;
   logic                 push;

   always_comb begin
      state_d   = state_q;
      wr_tick_d = 1'b0;
      rd_tick_d = 1'b0;
      rd_port_d = rd_port_q;
      push      = 1'b0;
      case (state_q)
         IDLE: begin
            // Any IO cycle, decoded or not, is followed to its end so that
            // exactly one decision is made per bus transaction.
            if (s_iorq && (s_wr || s_rd)) begin
               state_d = WAIT_END;
               if (addr_hit) begin
                  if (s_wr) begin
                     // wr wins when both strobes are seen: read suppressed.
                     wr_tick_d = 1'b1;
                     push      = 1'b1;
                  end else begin
                     rd_tick_d = 1'b1;
                     rd_port_d = s_port;
                  end
               end
            end
         end
         WAIT_END: begin
            if (s_valid && !s_iorq && !s_wr && !s_rd) state_d = IDLE;
         end
         default: state_d = WAIT_END;
      endcase
   end

   always_ff @(posedge phi) begin
      if (reset) begin
         state_q   <= WAIT_END;
         wr_tick_q <= 1'b0;
         rd_tick_q <= 1'b0;
         rd_port_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_tick_q <= wr_tick_d;
         rd_tick_q <= rd_tick_d;
         rd_port_q <= rd_port_d;
      end
   end

   // ------------------------------------------------------------ write queue
   // The push is applied on the same edge that raises wr_tick, so wq_valid
   // rises together with the tick when the queue was empty.
   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          pop, full, do_push;
   logic [EW-1:0] push_data;

   assign full      = (count_q == CW'(DEPTH));
   assign pop       = wq_pop && (count_q != '0);
   // A simultaneous pop frees the slot, so a push into a full queue still lands.
   assign do_push   = push && (!full || pop);
   assign push_data = {s_port, s_din};

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (push && full && !pop) ovf_d = 1'b1;
   end

   always_ff @(posedge phi) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: contents are only visible while wq_valid=1.
   always_ff @(posedge phi) begin
      if (do_push && !reset) mem_q[wr_ptr_q] <= push_data;
   end

   // ----------------------------------------------------------------- outputs
   assign wr_tick              = wr_tick_q;
   assign rd_tick              = rd_tick_q;
   assign rd_port              = rd_port_q;
   assign wq_valid             = (count_q != '0);
   assign {wq_port, wq_data}   = mem_q[rd_ptr_q];
   assign wq_full              = full;
   assign wq_overflow          = ovf_q;

endmodule

// File: tb/tb_z80_io_port_fsm.sv
module tb_z80_io_port_fsm;

`ifdef IORQ_DOUBLE_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 1;
`endif

   logic       phi = 1'b0, reset = 1'b1;
   logic       iorq = 1'b0, wr = 1'b0, rd = 1'b0;
   logic [7:0] ain = 8'h00, din = 8'h00;
   logic       wq_pop = 1'b0;
   logic       wr_tick, rd_tick, wq_valid, wq_full, wq_overflow;
   logic [1:0] rd_port, wq_port;
   logic [7:0] wq_data;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   int k;

   typedef struct {
      logic       is_wr;
      logic [1:0] port;
      int         cyc;
   } tick_t;

   tick_t      exp_tick[$];
   logic [9:0] exp_wq[$];

   z80_io_port_fsm #(
      .ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE_ADDR(8'h80), .PORT_BITS(2), .DEPTH(4)
   ) dut (
      .phi(phi), .reset(reset), .iorq(iorq), .wr(wr), .rd(rd), .ain(ain), .din(din),
      .wr_tick(wr_tick), .rd_tick(rd_tick), .rd_port(rd_port),
      .wq_valid(wq_valid), .wq_port(wq_port), .wq_data(wq_data), .wq_pop(wq_pop),
      .wq_full(wq_full), .wq_overflow(wq_overflow)
   );

   always #20 phi = ~phi;
   always @(posedge phi) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares ticks and queue pops against the scoreboard queues.
   task automatic monitor();
      tick_t e;
      forever begin
         @(negedge phi);
         if (wr_tick || rd_tick) begin
            if (exp_tick.size() == 0) check("tick_unexpected", 32'({wr_tick, rd_tick}), 32'd0);
            else begin
               e = exp_tick.pop_front();
               check("tick_kind", 32'({wr_tick, rd_tick}), e.is_wr ? 32'd2 : 32'd1);
               check("tick_cycle", 32'(cyc), 32'(e.cyc));
               if (!e.is_wr) check("tick_rd_port", 32'(rd_port), 32'(e.port));
            end
         end
         if (wq_pop && wq_valid) begin
            if (exp_wq.size() == 0) check("wq_unexpected_valid", 32'(wq_valid), 32'd0);
            else check("wq_head", 32'({wq_port, wq_data}), 32'(exp_wq.pop_front()));
         end
      end
   endtask

   // One bus transaction; strobes change dly after the rising edge and are
   // held for len phi cycles. Expectations are pushed from the bench's decode.
   task automatic bus_cycle(input logic w, input logic r, input logic [7:0] a,
                            input logic [7:0] d, input int dly, input int len, input bit qpush);
      tick_t e;
      @(posedge phi); #(dly);
      ain = a; din = d; iorq = 1'b1; wr = w; rd = r;
      if (a[7:2] == 6'b100000) begin
         e.is_wr = w;
         e.port  = a[1:0];
         e.cyc   = cyc + 1 + SYNC;
         exp_tick.push_back(e);
         if (w && qpush) exp_wq.push_back({a[1:0], d});
      end
      repeat (len) @(posedge phi);
      #(dly);
      iorq = 1'b0; wr = 1'b0; rd = 1'b0;
      repeat (3) @(posedge phi);
   endtask

   task automatic pop_one();
      @(posedge phi); #1 wq_pop = 1'b1;
      @(posedge phi); #1 wq_pop = 1'b0;
   endtask

   task automatic apply_reset();
      @(posedge phi); #1 reset = 1'b1;
      repeat (2) @(posedge phi);
      #1 reset = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_wr_tick"},     32'(wr_tick),     32'd0);
      check({tag, "_rd_tick"},     32'(rd_tick),     32'd0);
      check({tag, "_rd_port"},     32'(rd_port),     32'd0);
      check({tag, "_wq_valid"},    32'(wq_valid),    32'd0);
      check({tag, "_wq_full"},     32'(wq_full),     32'd0);
      check({tag, "_wq_overflow"}, 32'(wq_overflow), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      fork monitor(); join_none

      // Power-up reset
      repeat (3) @(posedge phi);
      #1 reset = 1'b0;
      @(negedge phi);
      check_reset_vals("por");

      // 4-T write, moderate timing
      bus_cycle(1'b1, 1'b0, 8'h81, 8'h23, 5, 3, 1'b1);
      @(negedge phi);
      check("w1_valid", 32'(wq_valid), 32'd1);
      check("w1_port",  32'(wq_port),  32'd1);
      check("w1_data",  32'(wq_data),  32'h23);
      check("w1_full",  32'(wq_full),  32'd0);
      pop_one();
      @(negedge phi);
      check("w1_empty", 32'(wq_valid), 32'd0);

      // Same write, late strobes and long Tw extension
      bus_cycle(1'b1, 1'b0, 8'h81, 8'h23, 25, 10, 1'b1);
      @(negedge phi);
      check("w2_valid", 32'(wq_valid), 32'd1);
      check("w2_port",  32'(wq_port),  32'd1);
      check("w2_data",  32'(wq_data),  32'h23);
      pop_one();

      // Decoded read
      bus_cycle(1'b0, 1'b1, 8'h83, 8'h00, 5, 3, 1'b1);
      @(negedge phi);
      check("rd_port_3",   32'(rd_port),  32'd3);
      check("rd_no_queue", 32'(wq_valid), 32'd0);

      // Out-of-block write and read: nothing happens
      bus_cycle(1'b1, 1'b0, 8'h90, 8'h55, 5, 3, 1'b1);
      bus_cycle(1'b0, 1'b1, 8'h90, 8'h00, 5, 3, 1'b1);
      @(negedge phi);
      check("miss_valid",   32'(wq_valid), 32'd0);
      check("miss_rd_port", 32'(rd_port),  32'd3);

      // wr and rd both high: write only
      bus_cycle(1'b1, 1'b1, 8'h80, 8'h5A, 5, 3, 1'b1);
      @(negedge phi);
      check("wrrd_rd_port", 32'(rd_port),  32'd3);
      check("wrrd_valid",   32'(wq_valid), 32'd1);
      check("wrrd_port",    32'(wq_port),  32'd0);
      pop_one();

      // Five writes into a 4-deep queue without popping
      for (int i = 1; i <= 5; i++) bus_cycle(1'b1, 1'b0, 8'h82, 8'(i), 5, 3, (i <= 4));
      @(negedge phi);
      check("ovf_full",     32'(wq_full),     32'd1);
      check("ovf_overflow", 32'(wq_overflow), 32'd1);
      check("ovf_valid",    32'(wq_valid),    32'd1);
      repeat (4) pop_one();
      @(negedge phi);
      check("ovf_drained",  32'(wq_valid),    32'd0);
      check("ovf_not_full", 32'(wq_full),     32'd0);
      check("ovf_sticky",   32'(wq_overflow), 32'd1);

      // Full queue, pop coincident with push: nothing dropped
      apply_reset();
      @(negedge phi);
      check("rst_ovf_clear", 32'(wq_overflow), 32'd0);
      for (int i = 0; i < 4; i++) bus_cycle(1'b1, 1'b0, 8'h81, 8'(8'h11 + i), 5, 3, 1'b1);
      @(negedge phi);
      check("pp_full_before", 32'(wq_full), 32'd1);
      fork
         bus_cycle(1'b1, 1'b0, 8'h83, 8'hAA, 5, 3, 1'b1);
         begin
            wait (iorq == 1'b1);
            k = cyc;
            while (cyc != k + SYNC) begin @(posedge phi); #1; end
            wq_pop = 1'b1;
            @(posedge phi); #1 wq_pop = 1'b0;
         end
      join
      @(negedge phi);
      check("pp_full_after", 32'(wq_full),     32'd1);
      check("pp_no_ovf",     32'(wq_overflow), 32'd0);
      repeat (4) pop_one();
      @(negedge phi);
      check("pp_drained", 32'(wq_valid), 32'd0);

      // Reset asserted mid-write and released while the write is still active
      @(posedge phi); #5;
      ain = 8'h81; din = 8'h99; iorq = 1'b1; wr = 1'b1;
      @(posedge phi); #1 reset = 1'b1;
      repeat (2) @(posedge phi);
      #1 reset = 1'b0;
      @(negedge phi);
      check_reset_vals("mid_rst");
      repeat (3) @(posedge phi);
      #5 iorq = 1'b0; wr = 1'b0;
      repeat (3) @(posedge phi);
      @(negedge phi);
      check_reset_vals("post_rst");

      // Normal operation resumes
      bus_cycle(1'b1, 1'b0, 8'h82, 8'h77, 5, 3, 1'b1);
      pop_one();

      repeat (5) @(posedge phi);
      check("ticks_all_seen",  32'(exp_tick.size()), 32'd0);
      check("queue_all_seen",  32'(exp_wq.size()),   32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
